// File: rtl/alu_bist_pkg.sv
// Shared constants, state encoding and signature helpers for the ALU built-in self-test.
package alu_bist_pkg;

   localparam int OPS_PER_VEC = 10;

   // Function codes walked per vector; entry 0 is the least significant nibble.
   localparam logic [9:0][3:0] OP_TABLE = {
      4'b1011, 4'b1010, 4'b0111, 4'b0110, 4'b0101,
      4'b0100, 4'b0011, 4'b0010, 4'b0001, 4'b0000
   };

   // Feedback taps at bits 31, 21, 1 and 0.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] MISR_TAPS = 32'h8020_0003;
   localparam logic [31:0] SRCB_MASK = 32'hA5A5_A5A5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [31:0] shift_fb(input logic [31:0] s, input logic [31:0] taps);
      return {s[30:0], ^(s & taps)};
   endfunction

   function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] res,
                                             input logic z, input logic n, input logic o);
      return shift_fb(s, MISR_TAPS) ^ res ^ {29'b0, z, n, o};
   endfunction

   function automatic logic [31:0] srcb_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ SRCB_MASK;
   endfunction

   function automatic logic [3:0] op_code(input logic [4:0] idx);
      logic [4:0] k;
      logic [3:0] r;
      k = (idx >= 5'(OPS_PER_VEC)) ? idx - 5'(OPS_PER_VEC) : idx;
      case (k)
         5'd0:    r = OP_TABLE[0];
         5'd1:    r = OP_TABLE[1];
         5'd2:    r = OP_TABLE[2];
         5'd3:    r = OP_TABLE[3];
         5'd4:    r = OP_TABLE[4];
         5'd5:    r = OP_TABLE[5];
         5'd6:    r = OP_TABLE[6];
         5'd7:    r = OP_TABLE[7];
         5'd8:    r = OP_TABLE[8];
         5'd9:    r = OP_TABLE[9];
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Fibonacci LFSR operand generator with synchronous load and step.
module lfsr32
   import alu_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] q,
   output logic [31:0] nxt
);

   logic [31:0] lfsr_r;

   assign nxt = shift_fb(lfsr_r, LFSR_TAPS);
   assign q   = lfsr_r;

   // LFSR register: load has priority over step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= seed;
      end else if (load) begin
         lfsr_r <= seed;
      end else if (step) begin
         lfsr_r <= nxt;
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test sequencer: drives every function code per LFSR vector and
// compresses the ALU response into a MISR signature checked against GOLDEN.
module alu_bist
   import alu_bist_pkg::*;
#(
   parameter int          NUM_VEC = 16,
   parameter logic [31:0] SEED    = 32'h0000_0003,
   parameter logic [31:0] GOLDEN  = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] signature,
   output logic        i,
   output logic [31:0] SrcA,
   output logic [31:0] SrcB,
   output logic [3:0]  af,
   input  logic [31:0] Alures,
   input  logic        Zero,
   input  logic        Neg,
   input  logic        ovfalu
);

   localparam int          VW       = $clog2(NUM_VEC) + 1;
   localparam logic [VW-1:0] LAST_VEC = VW'(NUM_VEC - 1);
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
   localparam logic [4:0]  IDX_LAST = 5'(2 * OPS_PER_VEC - 1);

   state_t        state_r, state_n;
   logic [4:0]    idx_r, idx_n;
   logic [VW-1:0] vec_r, vec_n;
   logic [31:0]   misr_r, misr_n, misr_upd_s;
   logic          done_r, done_n, pass_r, pass_n, busy_r;
   logic          load_s, step_s, drive_s;
   logic [31:0]   lfsr_q_s, lfsr_nxt_s, opnd_s;
   logic          i_r;
   logic [31:0]   srca_r, srcb_r;
   logic [3:0]    af_r;

   lfsr32 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s),
      .step  (step_s),
      .seed  (SEED_EFF),
      .q     (lfsr_q_s),
      .nxt   (lfsr_nxt_s)
   );

   assign misr_upd_s = misr_next(misr_r, Alures, Zero, Neg, ovfalu);
   assign opnd_s     = load_s ? SEED_EFF : (step_s ? lfsr_nxt_s : lfsr_q_s);

   // Next-state, sequencing counters and MISR/result update.
   always_comb begin
      state_n = state_r;
      idx_n   = idx_r;
      vec_n   = vec_r;
      misr_n  = misr_r;
      done_n  = done_r;
      pass_n  = pass_r;
      load_s  = 1'b0;
      step_s  = 1'b0;
      drive_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_n = ST_RUN;
               idx_n   = 5'd0;
               vec_n   = '0;
               misr_n  = 32'h0;
               done_n  = 1'b0;
               pass_n  = 1'b0;
               load_s  = 1'b1;
               drive_s = 1'b1;
            end else begin
               state_n = state_r;
            end
         end
         ST_RUN: begin
            misr_n  = misr_upd_s;
            drive_s = 1'b1;
            if (idx_r == IDX_LAST) begin
               idx_n  = 5'd0;
               vec_n  = vec_r + VW'(1);
               step_s = 1'b1;
            end else begin
               idx_n  = idx_r + 5'd1;
            end
            // The op about to be driven is the final one of the run.
            if ((idx_r == IDX_LAST - 5'd1) && (vec_r == LAST_VEC)) begin
               state_n = ST_FLUSH;
            end else begin
               state_n = ST_RUN;
            end
         end
         ST_FLUSH: begin
            misr_n  = misr_upd_s;
            state_n = ST_DONE;
            done_n  = 1'b1;
            pass_n  = (misr_upd_s == GOLDEN);
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Counters, signature, status and registered ALU-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r  <= 5'd0;
         vec_r  <= '0;
         misr_r <= 32'h0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
         busy_r <= 1'b0;
         i_r    <= 1'b0;
         af_r   <= 4'h0;
         srca_r <= 32'h0;
         srcb_r <= 32'h0;
      end else begin
         idx_r  <= idx_n;
         vec_r  <= vec_n;
         misr_r <= misr_n;
         done_r <= done_n;
         pass_r <= pass_n;
         busy_r <= (state_n == ST_RUN) || (state_n == ST_FLUSH);
         if (drive_s) begin
            i_r    <= (idx_n < 5'(OPS_PER_VEC));
            af_r   <= op_code(idx_n);
            srca_r <= opnd_s;
            srcb_r <= srcb_of(opnd_s);
         end else begin
            i_r    <= 1'b0;
            af_r   <= 4'h0;
            srca_r <= 32'h0;
            srcb_r <= 32'h0;
         end
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign signature = misr_r;
   assign i         = i_r;
   assign af        = af_r;
   assign SrcA      = srca_r;
   assign SrcB      = srcb_r;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: behavioural ALU/stub plus an op-sequence and signature model.
module tb_alu_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start_a, start_b;
   logic busy_a, done_a, pass_a, i_a, z_a, n_a, o_a;
   logic busy_b, done_b, pass_b, i_b, z_b, n_b, o_b;
   logic [31:0] sig_a, srca_a, srcb_a, res_a;
   logic [31:0] sig_b, srca_b, srcb_b, res_b;
   logic [3:0]  af_a, af_b;
   int mode_a, mode_b;
   int total = 0;
   int bad = 0;

   function automatic logic [31:0] lfsr_step(input logic [31:0] q);
      return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
   endfunction

   function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [34:0] r);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ r[34:3] ^ {29'b0, r[2:0]};
   endfunction

   function automatic logic [3:0] tb_af(input int idx);
      int k;
      k = idx % 10;
      return (k < 8) ? 4'(k) : 4'(k + 2);
   endfunction

   function automatic logic [31:0] swap_mask(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5A5_A5A5;
   endfunction

   // Reference ALU: returns {result, zero, neg, overflow}.
   function automatic logic [34:0] alu_model(input logic [3:0] f, input logic imm,
                                             input logic [31:0] a, input logic [31:0] b);
      logic [31:0] bb, r;
      logic o;
      bb = imm ? {16'h0, b[15:0]} : b;
      o  = 1'b0;
      case (f)
         4'd0:  begin r = a + bb; o = (a[31] == bb[31]) && (r[31] != a[31]); end
         4'd1:  begin r = a - bb; o = (a[31] != bb[31]) && (r[31] != a[31]); end
         4'd2:  r = a & bb;
         4'd3:  r = a | bb;
         4'd4:  r = a ^ bb;
         4'd5:  r = ~(a | bb);
         4'd6:  r = {31'b0, $signed(a) < $signed(bb)};
         4'd7:  r = {31'b0, a < bb};
         4'd10: r = a << bb[4:0];
         4'd11: r = a >> bb[4:0];
         default: r = 32'h0;
      endcase
      return {r, r == 32'h0, r[31], o};
   endfunction

   function automatic logic [34:0] stub(input int mode, input logic [3:0] f, input logic imm,
                                        input logic [31:0] a, input logic [31:0] b);
      logic [34:0] r;
      case (mode)
         0:       r = 35'h0;
         1:       r = {32'h1, 3'b000};
         2:       r = alu_model(f, imm, a, b);
         default: r = alu_model(f, imm, a, b) | 35'h1;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] model_sig(input logic [31:0] seed, input int nvec, input int mode);
      logic [31:0] a, s;
      a = (seed == 32'h0) ? 32'h1 : seed;
      s = 32'h0;
      for (int v = 0; v < nvec; v++) begin
         for (int x = 0; x < 20; x++) begin
            s = sig_step(s, stub(mode, tb_af(x), x < 10, a, swap_mask(a)));
         end
         a = lfsr_step(a);
      end
      return s;
   endfunction

   localparam logic [31:0] GOLD_B = model_sig(32'h0, 1, 2);

   always_comb {res_a, z_a, n_a, o_a} = stub(mode_a, af_a, i_a, srca_a, srcb_a);
   always_comb {res_b, z_b, n_b, o_b} = stub(mode_b, af_b, i_b, srca_b, srcb_b);

   alu_bist #(.NUM_VEC(2), .SEED(32'h3), .GOLDEN(32'h0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .signature(sig_a), .i(i_a), .SrcA(srca_a), .SrcB(srcb_a), .af(af_a),
      .Alures(res_a), .Zero(z_a), .Neg(n_a), .ovfalu(o_a)
   );

   alu_bist #(.NUM_VEC(1), .SEED(32'h0), .GOLDEN(GOLD_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .signature(sig_b), .i(i_b), .SrcA(srca_b), .SrcB(srcb_b), .af(af_b),
      .Alures(res_b), .Zero(z_b), .Neg(n_b), .ovfalu(o_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, "_busy"}, 32'(busy_a), 32'h0);
      chk({tag, "_done"}, 32'(done_a), 32'h0);
      chk({tag, "_pass"}, 32'(pass_a), 32'h0);
      chk({tag, "_sig"},  sig_a, 32'h0);
      chk({tag, "_srca"}, srca_a, 32'h0);
      chk({tag, "_srcb"}, srcb_a, 32'h0);
      chk({tag, "_i"},    32'(i_a), 32'h0);
      chk({tag, "_af"},   32'(af_a), 32'h0);
   endtask

   // One run of instance A; rst_at >= 0 aborts with an asynchronous reset at that op.
   task automatic run_a(input int mode, input int rst_at);
      logic [31:0] a, b, sig;
      int poke, idx;
      a = 32'h3;
      sig = 32'h0;
      mode_a = mode;
      poke = $urandom_range(1, 39);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         start_a = (k == poke);
         idx = k % 20;
         if (k > 0 && idx == 0) a = lfsr_step(a);
         b = swap_mask(a);
         chk("busy", 32'(busy_a), 32'h1);
         chk("done_low", 32'(done_a), 32'h0);
         chk("srca", srca_a, a);
         chk("srcb", srcb_a, b);
         chk("imm", 32'(i_a), 32'(idx < 10));
         chk("af", 32'(af_a), 32'(tb_af(idx)));
         chk("sig", sig_a, sig);
         if (k == rst_at) begin
            #2 rst_n = 1'b0;
            #1 chk_zero_a("async_rst");
            start_a = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         sig = sig_step(sig, stub(mode, tb_af(idx), idx < 10, a, b));
      end
      @(negedge clk);
      start_a = 1'b0;
      chk("done_high", 32'(done_a), 32'h1);
      chk("busy_end", 32'(busy_a), 32'h0);
      chk("pass", 32'(pass_a), 32'(sig == 32'h0));
      chk("sig_end", sig_a, sig);
      chk("srca_end", srca_a, 32'h0);
      chk("af_end", 32'(af_a), 32'h0);
   endtask

   // One run of instance B (NUM_VEC=1, SEED=0, GOLDEN from the model).
   task automatic run_b(input int mode);
      logic [31:0] exp_sig;
      int cycles;
      mode_b = mode;
      exp_sig = model_sig(32'h0, 1, mode);
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      chk("b_seed_fix", srca_b, 32'h1);
      cycles = 0;
      while (!done_b && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      chk("b_done", 32'(done_b), 32'h1);
      chk("b_latency", 32'(cycles), 32'd20);
      chk("b_sig", sig_b, exp_sig);
      chk("b_pass", 32'(pass_b), 32'(exp_sig == GOLD_B));
   endtask

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      mode_a  = 0;
      mode_b  = 2;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start_a = ~start_a;
         start_b = ~start_b;
      end
      chk_zero_a("in_reset");
      chk("b_busy_rst", 32'(busy_b), 32'h0);
      chk("b_done_rst", 32'(done_b), 32'h0);
      start_a = 1'b0;
      start_b = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_a(0, -1);
      run_a(1, -1);
      run_a(2, 7);
      chk_zero_a("after_rst");
      run_a(2, -1);
      run_b(2);
      run_b(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
